// File: rtl/sram_req_arbiter_if.sv
// Sram-like request/response bus: one address phase per req/addr_ok, one data_ok per accepted request.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between the inst and data masters; data has priority, a stalled
// address phase keeps its grant, and an in-order ID FIFO routes each data_ok back to its issuer.
module sram_req_arbiter #(
  parameter int unsigned OUTS_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  sram_req_arbiter_if.slave         inst_if,
  sram_req_arbiter_if.slave         data_if,
  sram_req_arbiter_if.master        mem_if,
  output logic                      resp_err
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_LOCK_I = 2'd1,
    S_LOCK_D = 2'd2
  } state_e;

  state_e                  state_q;
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [OUTS_DEPTH-1:0]   ids_q;
  logic                    resp_err_q;

  logic full;
  logic empty;
  logic gnt_valid;
  logic gnt_data;
  logic sel_req;
  logic mem_req;
  logic push;
  logic pop;
  logic head_id;

  assign full  = (cnt_q == CNT_W'(OUTS_DEPTH));
  assign empty = (cnt_q == '0);

  // Grant: locked master wins outright; otherwise data over inst, and nobody while full.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = 1'b0;
    case (state_q)
      S_LOCK_I: gnt_valid = 1'b1;
      S_LOCK_D: begin
        gnt_valid = 1'b1;
        gnt_data  = 1'b1;
      end
      default: begin
        if (!full) begin
          if (data_if.req) begin
            gnt_valid = 1'b1;
            gnt_data  = 1'b1;
          end else if (inst_if.req) begin
            gnt_valid = 1'b1;
          end
        end
      end
    endcase
  end

  assign sel_req = gnt_data ? data_if.req : inst_if.req;
  assign mem_req = gnt_valid & sel_req & ~full;
  assign push    = mem_req & mem_if.addr_ok;

  always_comb begin
    mem_if.wr    = 1'b0;
    mem_if.size  = 2'd0;
    mem_if.wstrb = 4'd0;
    mem_if.addr  = 32'd0;
    mem_if.wdata = 32'd0;
    if (gnt_valid && gnt_data) begin
      mem_if.wr    = data_if.wr;
      mem_if.size  = data_if.size;
      mem_if.wstrb = data_if.wstrb;
      mem_if.addr  = data_if.addr;
      mem_if.wdata = data_if.wdata;
    end else if (gnt_valid) begin
      mem_if.wr    = inst_if.wr;
      mem_if.size  = inst_if.size;
      mem_if.wstrb = inst_if.wstrb;
      mem_if.addr  = inst_if.addr;
      mem_if.wdata = inst_if.wdata;
    end
  end

  assign mem_if.req      = mem_req;
  assign inst_if.addr_ok = push & ~gnt_data;
  assign data_if.addr_ok = push & gnt_data;

  // Responses come back in issue order, so the FIFO head names the owner.
  assign head_id         = ids_q[rd_ptr_q];
  assign pop             = mem_if.data_ok & ~empty;
  assign inst_if.data_ok = pop & ~head_id;
  assign data_if.data_ok = pop & head_id;
  assign inst_if.rdata   = mem_if.rdata;
  assign data_if.rdata   = mem_if.rdata;
  assign resp_err        = resp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FREE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ids_q      <= '0;
      resp_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          if (mem_req && !mem_if.addr_ok) begin
            state_q <= gnt_data ? S_LOCK_D : S_LOCK_I;
          end
        end
        S_LOCK_I: if (!inst_if.req || mem_if.addr_ok) state_q <= S_FREE;
        S_LOCK_D: if (!data_if.req || mem_if.addr_ok) state_q <= S_FREE;
        default:  state_q <= S_FREE;
      endcase

      if (push) begin
        ids_q[wr_ptr_q] <= gnt_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase

      // A response with nothing outstanding means the memory side lost sync.
      if (mem_if.data_ok && empty) begin
        resp_err_q <= 1'b1;
      end
    end
  end

endmodule
